spi_bus_bridge: RTL and testbench
=================================

# spi_bus_bridge

Command decoder directly downstream of `spislave`. Consumes received bytes (`mdata` strobed by `data_valid_read`, framed by `data_firstbyte`), decodes a read/write command plus 15-bit address, and runs auto-incrementing byte transfers on a req/ack memory bus. Read data is returned to `spislave` through `sdata` for the following SPI byte.

## Interface
- `ADDR_W`, 15: bus address width; wraps modulo 2^ADDR_W.
- `clk`  in  1  system clock, same domain as `spislave`.
- `rst`  in  1  asynchronous, active-low reset.
- `mdata`  in  8  byte received from SPI master.
- `data_valid_read`  in  1  one-cycle strobe: `mdata` valid.
- `data_firstbyte`  in  1  qualifies the strobe: first byte after CS assert.
- `sdata`  out  8  byte shifted out on the next SPI byte.
- `bus_req`  out  1  transaction request, held until ack.
- `bus_we`  out  1  1 = write, 0 = read; stable while `bus_req`.
- `bus_addr`  out  ADDR_W  transaction address; stable while `bus_req`.
- `bus_wdata`  out  8  write data; stable while `bus_req`.
- `bus_rdata`  in  8  read data, valid in the `bus_ack` cycle.
- `bus_ack`  in  1  one-cycle completion strobe.
- `overrun`  out  1  sticky: a byte arrived while a bus transaction was pending.

## Operation
- Frame format:
  - Byte 0 (`data_firstbyte`=1) has two fields: cmd[7] = write(1)/read(0), and cmd[6:0] = addr[14:8].
  - Byte 1 = addr[7:0].
  - Bytes 2+ = data.
- States:
  - IDLE: waits for a first byte.
  - ADDR: waits for the address low byte.
  - DATA: streams data bytes.
  - Bus pending is tracked by `bus_req`, orthogonal to the state.
- IDLE: a strobe with `data_firstbyte`=1 latches direction and addr[14:8], then goes to ADDR. A strobe without `data_firstbyte` is ignored.
- ADDR: a strobe latches addr[7:0], then goes to DATA.
  - Read: immediately issue read at addr (prefetch).
  - Write: issue nothing.
- DATA, write: each strobe issues a write of `mdata` at addr, then addr++.
- DATA, read: each strobe issues a read at addr+1 and sets addr++. The byte master sends is ignored.
- Read ack: `sdata` <= `bus_rdata` in the ack cycle.
- `sdata` in write frames and in cmd/addr phases: {7'b0, `overrun`}. It is loaded on entering ADDR.
- Any strobe with `data_firstbyte`=1 restarts decode at ADDR, from any state.
- An outstanding bus transaction is never abandoned; `bus_req` stays high until `bus_ack`.
- A strobe arriving while `bus_req`=1 (other than a first byte) is dropped, no address increment, and sets `overrun`.
  - A first byte in that situation is still decoded.
- `overrun` clears only on reset or when a read command byte has cmd[6:0]=7'h7F. That address space is reserved for status.
- Address wrap: 0x7FFF+1 = 0x0000.

## Timing
- Reset values: `sdata`=0x00, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `overrun`=0, state IDLE.
- `bus_req` rises the cycle after the triggering strobe, together with `bus_we`/`bus_addr`/`bus_wdata`.
- `bus_req` falls the cycle after `bus_ack`.
- `bus_ack` while `bus_req`=0 is ignored.
- `bus_ack` in the same cycle as a strobe: the ack completes first, so the strobe is accepted and not counted as overrun. A new `bus_req` follows the next cycle.
- Read data returns to the master one SPI byte after its request. Bus ack must arrive within 7 SPI bit times, otherwise the master sees stale `sdata`.
- Asserting reset mid-transaction drops `bus_req` immediately and asynchronously. The bus slave must tolerate this.

## Structure
- Shared package `spi_bus_pkg`: state enum (IDLE/ADDR/DATA), CMD_WRITE_BIT=7, STATUS_ADDR_HI=7'h7F, default ADDR_W.
- One natural sub-module, `bus_req_ctrl`: holds req/we/addr/wdata, detects ack, and reports pending to the decoder.

## Test plan
- Write frame 0x81,0x23,0x11,0x22 -> writes 0x11@0x0123, then 0x22@0x0124; `sdata`=0x00; `overrun`=0.
- Read frame 0x00,0x10,xx,xx, with bus returning 0xAB then 0xCD -> reads @0x0010 and @0x0011 issued; `sdata`=0xAB after ack 1, then 0xCD after ack 2.
- Write at 0x7FFF with two data bytes -> second write targets 0x0000.
- Strobe while ack withheld -> byte dropped, address unchanged, `overrun`=1, `sdata`=0x01 after next command.
  - Then read command 0x7F -> `overrun`=0.
- First byte mid-DATA with a write pending -> `bus_req` held until ack, then new command decoded.
- Reset asserted mid-read with `bus_req`=1 -> all outputs at reset values immediately; a subsequent valid frame works.

Source files
------------

// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI-to-bus bridge.
// Holds the decoder state encoding, command byte field positions and the
// default bus address width.
package spi_bus_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 15;

    // Command byte: bit 7 selects write (1) or read (0), bits 6:0 give addr[14:8].
    localparam int unsigned CMD_WRITE_BIT = 7;

    // Reading with this high address byte clears the sticky overrun flag.
    localparam logic [6:0] STATUS_ADDR_HI = 7'h7F;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

endpackage

// File: rtl/bus_req_ctrl.sv
// Bus request holder for the SPI bridge.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   issue_i            launch a transaction next cycle (only when not pending)
//   issue_we_i/addr/wdata  transaction attributes captured with issue_i
//   bus_ack_i          one-cycle completion strobe from the bus slave
//   bus_req_o/we/addr/wdata  registered bus outputs, stable while bus_req_o
//   pending_o          request outstanding and not completing this cycle
//   ack_o              ack accepted this cycle (ack while req is low is ignored)
module bus_req_ctrl #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              issue_i,
    input  logic              issue_we_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [7:0]        issue_wdata_i,
    input  logic              bus_ack_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    output logic              pending_o,
    output logic              ack_o
);

    logic              req_d, req_q;
    logic              we_d, we_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [7:0]        wdata_d, wdata_q;

    assign ack_o     = req_q & bus_ack_i;
    // An ack completes first, so a strobe in the ack cycle sees the bus free.
    assign pending_o = req_q & ~bus_ack_i;

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (issue_i) begin
            req_d   = 1'b1;
            we_d    = issue_we_i;
            addr_d  = issue_addr_i;
            wdata_d = issue_wdata_i;
        end else if (ack_o) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// Command decoder behind the SPI slave: turns received byte frames
// (cmd, addr-low, data...) into auto-incrementing req/ack bus transfers.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   mdata_i, data_valid_read_i  received byte and its one-cycle strobe
//   data_firstbyte_i            strobe qualifier: first byte of a CS frame
//   sdata_o                     byte returned to the master on the next SPI byte
//   bus_req_o/we/addr/wdata     memory bus request, held until bus_ack_i
//   bus_rdata_i, bus_ack_i      bus read data and completion strobe
//   overrun_o                   sticky: byte arrived while the bus was busy
module spi_bus_bridge
    import spi_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        mdata_i,
    input  logic              data_valid_read_i,
    input  logic              data_firstbyte_i,
    output logic [7:0]        sdata_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [7:0]        bus_wdata_o,
    input  logic [7:0]        bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              overrun_o
);

    state_e            state_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        sdata_q;
    logic              overrun_q;

    logic              pending;
    logic              ack;
    logic              first;
    logic              accept;
    logic              issue;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;

    assign first  = data_valid_read_i & data_firstbyte_i;
    assign accept = data_valid_read_i & ~data_firstbyte_i & ~pending;

    always_comb begin
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = addr_q;
        if (accept) begin
            unique case (state_q)
                StAddr: begin
                    // Read prefetch at the freshly completed address.
                    issue      = ~write_q;
                    issue_addr = {addr_q[ADDR_W-1:8], mdata_i};
                end
                StData: begin
                    issue      = 1'b1;
                    issue_we   = write_q;
                    issue_addr = write_q ? addr_q : addr_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            write_q   <= 1'b0;
            addr_q    <= '0;
            sdata_q   <= 8'h00;
            overrun_q <= 1'b0;
        end else if (first) begin
            // Restart decode from any state; a pending transfer keeps running.
            state_q <= StAddr;
            write_q <= mdata_i[CMD_WRITE_BIT];
            addr_q  <= ADDR_W'({mdata_i[6:0], 8'h00});
            // Status byte shows the flag as it was before a possible clear.
            sdata_q <= {7'b0, overrun_q};
            if (!mdata_i[CMD_WRITE_BIT] && mdata_i[6:0] == STATUS_ADDR_HI) begin
                overrun_q <= 1'b0;
            end
        end else begin
            if (ack && !bus_we_o) begin
                sdata_q <= bus_rdata_i;
            end
            if (data_valid_read_i && pending) begin
                overrun_q <= 1'b1;
            end else if (accept) begin
                unique case (state_q)
                    StAddr: begin
                        addr_q  <= {addr_q[ADDR_W-1:8], mdata_i};
                        state_q <= StData;
                    end
                    StData: addr_q <= addr_q + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    bus_req_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_bus_req_ctrl (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_i       (issue),
        .issue_we_i    (issue_we),
        .issue_addr_i  (issue_addr),
        .issue_wdata_i (mdata_i),
        .bus_ack_i     (bus_ack_i),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .pending_o     (pending),
        .ack_o         (ack)
    );

    assign sdata_o   = sdata_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed self-checking bench for spi_bus_bridge.
module tb_spi_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic [7:0]  mdata;
    logic        valid;
    logic        firstb;
    logic [7:0]  sdata;
    logic        bus_req;
    logic        bus_we;
    logic [14:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    spi_bus_bridge #(
        .ADDR_W (15)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .mdata_i           (mdata),
        .data_valid_read_i (valid),
        .data_firstbyte_i  (firstb),
        .sdata_o           (sdata),
        .bus_req_o         (bus_req),
        .bus_we_o          (bus_we),
        .bus_addr_o        (bus_addr),
        .bus_wdata_o       (bus_wdata),
        .bus_rdata_i       (bus_rdata),
        .bus_ack_i         (bus_ack),
        .overrun_o         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one received byte for a single cycle; returns at the following negedge.
    task automatic send(input logic [7:0] b, input logic f);
        @(negedge clk);
        mdata  = b;
        valid  = 1'b1;
        firstb = f;
        @(negedge clk);
        valid  = 1'b0;
        firstb = 1'b0;
    endtask

    task automatic ack(input logic [7:0] r);
        @(negedge clk);
        bus_rdata = r;
        bus_ack   = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mdata     = 8'h00;
        valid     = 1'b0;
        firstb    = 1'b0;
        bus_rdata = 8'h00;
        bus_ack   = 1'b0;
        #12;
        check("rst_sdata",   32'(sdata),     32'h00);
        check("rst_req",     32'(bus_req),   32'h0);
        check("rst_we",      32'(bus_we),    32'h0);
        check("rst_addr",    32'(bus_addr),  32'h0);
        check("rst_wdata",   32'(bus_wdata), 32'h00);
        check("rst_overrun", 32'(overrun),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-first strobe in IDLE is ignored.
        send(8'h42, 1'b0);
        check("idle_ignore_req", 32'(bus_req), 32'h0);

        // Write frame 0x81,0x23,0x11,0x22.
        send(8'h81, 1'b1);
        check("wr_cmd_req", 32'(bus_req), 32'h0);
        send(8'h23, 1'b0);
        check("wr_addr_noreq", 32'(bus_req), 32'h0);
        send(8'h11, 1'b0);
        check("wr1_req",   32'(bus_req),   32'h1);
        check("wr1_we",    32'(bus_we),    32'h1);
        check("wr1_addr",  32'(bus_addr),  32'h0123);
        check("wr1_wdata", 32'(bus_wdata), 32'h11);
        ack(8'h00);
        check("wr1_req_drop", 32'(bus_req), 32'h0);
        send(8'h22, 1'b0);
        check("wr2_addr",  32'(bus_addr),  32'h0124);
        check("wr2_wdata", 32'(bus_wdata), 32'h22);
        ack(8'h00);
        check("wr_sdata",   32'(sdata),   32'h00);
        check("wr_overrun", 32'(overrun), 32'h0);

        // Read frame 0x00,0x10,xx,xx with prefetch.
        send(8'h00, 1'b1);
        send(8'h10, 1'b0);
        check("rd1_req",  32'(bus_req),  32'h1);
        check("rd1_we",   32'(bus_we),   32'h0);
        check("rd1_addr", 32'(bus_addr), 32'h0010);
        ack(8'hAB);
        check("rd1_sdata", 32'(sdata),   32'hAB);
        check("rd1_drop",  32'(bus_req), 32'h0);
        send(8'h55, 1'b0);
        check("rd2_addr", 32'(bus_addr), 32'h0011);
        ack(8'hCD);
        check("rd2_sdata", 32'(sdata), 32'hCD);

        // Address wrap at 0x7FFF.
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b0);
        check("wrap1_addr", 32'(bus_addr), 32'h7FFF);
        ack(8'h00);
        send(8'h02, 1'b0);
        check("wrap2_addr",  32'(bus_addr),  32'h0000);
        check("wrap2_wdata", 32'(bus_wdata), 32'h02);
        ack(8'h00);

        // Overrun: strobe while ack withheld.
        send(8'h81, 1'b1);
        send(8'h00, 1'b0);
        send(8'h33, 1'b0);
        check("ovr_first_addr", 32'(bus_addr), 32'h0100);
        send(8'h44, 1'b0);
        check("ovr_flag",  32'(overrun),   32'h1);
        check("ovr_addr",  32'(bus_addr),  32'h0100);
        check("ovr_wdata", 32'(bus_wdata), 32'h33);
        check("ovr_req",   32'(bus_req),   32'h1);
        ack(8'h00);
        send(8'h55, 1'b0);
        check("ovr_next_addr", 32'(bus_addr), 32'h0101);
        ack(8'h00);
        send(8'h82, 1'b1);
        check("ovr_status_sdata", 32'(sdata), 32'h01);
        send(8'h7F, 1'b1);
        check("ovr_clear", 32'(overrun), 32'h0);
        send(8'h00, 1'b1);
        check("ovr_cleared_sdata", 32'(sdata), 32'h00);

        // First byte mid-DATA while a write is pending.
        send(8'h80, 1'b1);
        send(8'h40, 1'b0);
        send(8'h66, 1'b0);
        check("mid_req", 32'(bus_req), 32'h1);
        send(8'h01, 1'b1);
        check("mid_held_req",  32'(bus_req),  32'h1);
        check("mid_held_addr", 32'(bus_addr), 32'h0040);
        check("mid_held_we",   32'(bus_we),   32'h1);
        check("mid_no_ovr",    32'(overrun),  32'h0);
        ack(8'h00);
        check("mid_drop", 32'(bus_req), 32'h0);
        send(8'h02, 1'b0);
        check("mid_new_addr", 32'(bus_addr), 32'h0102);
        check("mid_new_we",   32'(bus_we),   32'h0);
        ack(8'h77);
        check("mid_new_sdata", 32'(sdata), 32'h77);

        // Ack and strobe in the same cycle: strobe accepted, no overrun.
        send(8'h00, 1'b0);
        check("same_first_addr", 32'(bus_addr), 32'h0103);
        @(negedge clk);
        bus_rdata = 8'h88;
        bus_ack   = 1'b1;
        mdata     = 8'h00;
        valid     = 1'b1;
        @(negedge clk);
        bus_ack   = 1'b0;
        valid     = 1'b0;
        check("same_req",   32'(bus_req),  32'h1);
        check("same_addr",  32'(bus_addr), 32'h0104);
        check("same_sdata", 32'(sdata),    32'h88);
        check("same_ovr",   32'(overrun),  32'h0);

        // Asynchronous reset mid-read.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   32'(bus_req),  32'h0);
        check("arst_addr",  32'(bus_addr), 32'h0);
        check("arst_sdata", 32'(sdata),    32'h00);
        check("arst_we",    32'(bus_we),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h00, 1'b1);
        send(8'h05, 1'b0);
        check("post_rst_addr", 32'(bus_addr), 32'h0005);
        check("post_rst_req",  32'(bus_req),  32'h1);
        ack(8'h99);
        check("post_rst_sdata", 32'(sdata), 32'h99);

        // Ack with no request is ignored.
        ack(8'h12);
        check("stray_ack_sdata", 32'(sdata),   32'h99);
        check("stray_ack_req",   32'(bus_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
